serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial adder/subtractor that reuses a single full-adder cell over WIDTH clock cycles.
- Processes operands LSB-first, with a registered carry/borrow between bits.
- Trades latency for area against the parallel ripple adder/subtractor path.
- Sits between operand registers and the result display/consumer logic.
- Uses a valid/ready handshake on both operand input and result output.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 1).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands a, b, sub valid
start_ready  output  1  block idle, able to accept operands
a  input  WIDTH  minuend / addend A
b  input  WIDTH  subtrahend / addend B
sub  input  1  0 = A+B, 1 = A-B
res  output  WIDTH  result
cout  output  1  add: carry out; sub: borrow out (1 when A<B unsigned)
res_valid  output  1  res/cout/ovf valid
res_ready  input  1  consumer accepts result

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - Reset clears all registers to 0 and puts the FSM in IDLE.
  - During and after reset: res=0, cout=0, res_valid=0, ovf=0, start_ready=1.
- States: IDLE, RUN, DONE (2-bit encoding). start_ready=1 only in IDLE. res_valid=1 only in DONE.
- IDLE:
  - On start_valid=1 at a clk edge (accept edge):
    - Load shift register SA <= a.
    - Load SB <= b XOR {WIDTH{sub}}.
    - Load carry <= sub.
    - Load cnt <= 0 and latch op <= sub.
    - Go to RUN.
  - Inputs are sampled only at the accept edge; a/b/sub may change freely afterwards.
- RUN, every cycle:
  - s = SA[0]^SB[0]^carry.
  - c = (SA[0]&SB[0])|(SA[0]&carry)|(SB[0]&carry).
  - SA and SB shift right by 1.
  - Result shift register shifts right with s inserted at MSB.
  - carry <= c, cnt <= cnt+1.
  - When cnt == WIDTH-1:
    - Go to DONE.
    - cout <= op ? ~c : c.
    - Capture the final result into res.
- DONE:
  - res, cout, ovf held stable while res_valid=1 and res_ready=0.
  - On res_ready=1, go to IDLE next cycle. No operand accept occurs in the same cycle as result consume.
- Latency and throughput:
  - res_valid rises exactly WIDTH clk edges after the accept edge.
  - Minimum throughput: one operation per WIDTH+2 cycles.
- Arithmetic:
  - Result is modulo 2^WIDTH. Subtraction is two's complement (A + ~B + 1).
  - cnt is $clog2(WIDTH+1) bits wide; no wrap is possible.
- Boundary conditions:
  - start_valid in RUN/DONE is ignored; it does not queue.
  - res_ready in IDLE/RUN is ignored.
  - WIDTH=1: RUN lasts exactly one cycle.
  - rst_n asserted mid-RUN or mid-DONE aborts the operation. res_valid drops immediately (async) and no partial result is exposed.
  - res is not updated during RUN; it keeps the previous result until the new capture at DONE entry.

Optional Feature:
Macro ADDSUB_OVF_EN.
- Defined:
  - Output port ovf (1 bit) exists.
  - ovf <= carry-into-MSB XOR carry-out-of-MSB, i.e. signed two's-complement overflow, captured at DONE entry.
  - ovf is valid with res_valid, held in DONE, and reset to 0.
- Not defined:
  - ovf port and its register are absent.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=8, add 0x35+0x4A -> res=0x7F, cout=0, res_valid high exactly 8 edges after accept, start_ready low throughout RUN/DONE.
2. Add 0xFF+0x01 -> res=0x00, cout=1, ovf=0; add 0x00+0x00 -> res=0x00, cout=0.
3. Sub 0x10-0x20 -> res=0xF0, cout(borrow)=1; sub 0x20-0x10 -> res=0x10, cout=0; sub 0x55-0x55 -> res=0x00, cout=0.
4. (ADDSUB_OVF_EN) Add 0x7F+0x01 -> res=0x80, ovf=1; sub 0x80-0x01 -> res=0x7F, ovf=1; sub 0x05-0x03 -> ovf=0.
5. Backpressure: hold res_ready=0 for 5 cycles in DONE while driving start_valid=1 with new operands -> res/cout stable, start_ready=0, new operands not taken; release res_ready -> IDLE next cycle, then new operation accepted and computed correctly.
6. Pulse rst_n low at RUN cnt=3 -> res=0, cout=0, res_valid=0 immediately, start_ready=1; after release, add 0x12+0x34 -> res=0x46 after 8 edges.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional signed-overflow output ovf is enabled by defining ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   racc;
  logic [WIDTH-1:0]   racc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               op;
  logic               s;
  logic               c;

  // Single full-adder cell; the new sum bit enters the accumulator at the MSB.
  always_comb begin
    s                   = sa[0] ^ sb[0] ^ carry;
    c                   = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    racc_nxt            = racc >> 1;
    racc_nxt[WIDTH-1]   = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      racc        <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      op          <= 1'b0;
      res         <= '0;
      cout        <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf         <= 1'b0;
`endif
      res_valid   <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            // Subtraction as A + ~B + 1: invert B and seed the carry with 1.
            sa          <= a;
            sb          <= b ^ {WIDTH{sub}};
            carry       <= sub;
            cnt         <= '0;
            op          <= sub;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          racc  <= racc_nxt;
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Carry out of the MSB is inverted to report borrow on subtract.
            res       <= racc_nxt;
            cout      <= op ? ~c : c;
`ifdef ADDSUB_OVF_EN
            ovf       <= carry ^ c;
`endif
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: vector table plus random ops scored through a queue,
// with backpressure and mid-operation reset sequences. Define ADDSUB_OVF_EN to check ovf.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic [W-1:0] res;
  logic         cout;
  logic         res_valid;
  logic         res_ready;
`ifdef ADDSUB_OVF_EN
  logic         ovf_dut;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         q[$];
  logic [W-1:0] last_res;
  vec_t         tbl[11];

  serial_addsub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res         (res),
    .cout        (cout),
`ifdef ADDSUB_OVF_EN
    .ovf         (ovf_dut),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t       e;
    logic [W:0] full;
    if (!s) begin
      full   = {1'b0, x} + {1'b0, y};
      e.res  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    end else begin
      e.res  = x - y;
      e.cout = (x < y);
      e.ovf  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    end
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                        input exp_t e, input int hold);
    int   lat;
    exp_t got;
    @(negedge clk);
    check("idle_ready", start_ready, 1);
    a = ai; b = bi; sub = si; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    q.push_back(e);
    lat = 0;
    while (!res_valid && lat < W + 4) begin
      check("run_ready_low", start_ready, 0);
      check("run_res_hold", res, last_res);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, W);
    for (int i = 0; i < hold; i++) begin
      check("hold_ready_low", start_ready, 0);
      check("hold_valid", res_valid, 1);
      check("hold_res", res, q[0].res);
      check("hold_cout", cout, q[0].cout);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start_valid = 1'b1;
      @(negedge clk);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    got = q.pop_front();
    check("res", res, got.res);
    check("cout", cout, got.cout);
`ifdef ADDSUB_OVF_EN
    check("ovf", ovf_dut, got.ovf);
`endif
    @(negedge clk);
    res_ready = 1'b0;
    last_res  = got.res;
    check("consume_idle_ready", start_ready, 1);
    check("consume_valid_low", res_valid, 0);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic         rs;

    tbl[0]  = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0};
    tbl[4]  = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0};
    tbl[5]  = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[8]  = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[9]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; last_res = '0;
    repeat (2) @(negedge clk);
    check("rst_res", res, 0);
    check("rst_cout", cout, 0);
    check("rst_valid", res_valid, 0);
    check("rst_ready", start_ready, 1);
`ifdef ADDSUB_OVF_EN
    check("rst_ovf", ovf_dut, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      e.res = tbl[i].res; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, e, 0);
    end

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rs, model(ra, rb, rs), i % 3);
    end

    // Backpressure: result held 5 cycles while new operands are offered.
    e.res = 8'hF0; e.cout = 1'b1; e.ovf = 1'b0;
    run_op(8'h10, 8'h20, 1'b1, e, 5);
    run_op(8'h21, 8'h0F, 1'b0, model(8'h21, 8'h0F, 1'b0), 0);

    // Reset while RUN has cnt=3: everything must clear at once.
    @(negedge clk);
    a = 8'hAA; b = 8'h11; sub = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res", res, 0);
    check("abort_cout", cout, 0);
    check("abort_valid", res_valid, 0);
    check("abort_ready", start_ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = '0;
    e.res = 8'h46; e.cout = 1'b0; e.ovf = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
